ip_codma_bus_responder: RTL and testbench

// - Bus responder (target) for the codma bus: serves master requests from the read/write machines.
// - Arbitration handshake via grant; 64-bit read beats with read_valid; 64-bit write beats with write_valid.
// - Backed by an internal 32-bit word memory. Used as the system-memory model in block/top-level sims.
// - Synthesizable as a scratch RAM target.

---
 rtl/ip_codma_machine_states_pkg.sv | 47 ++++
 rtl/ip_codma_resp_mem.sv | 32 +++
 rtl/ip_codma_bus_responder.sv | 176 +++++++++++++++++
 tb/tb_ip_codma_bus_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_machine_states_pkg.sv
// Shared state encodings and transfer-size helpers for the codma bus machines.
// The responder FSM and its size decoding live here so master and target agree.
package ip_codma_machine_states_pkg;

  typedef enum logic [2:0] {
    RSP_IDLE  = 3'd0,
    RSP_GRANT = 3'd1,
    RSP_WAIT  = 3'd2,
    RSP_READ  = 3'd3,
    RSP_WRITE = 3'd4,
    RSP_DONE  = 3'd5
  } rsp_state_t;

  localparam logic [3:0] SIZE_1W = 4'd3;
  localparam logic [3:0] SIZE_4W = 4'd8;
  localparam logic [3:0] SIZE_8W = 4'd9;

  function automatic logic size_legal(input logic [3:0] size);
    return (size == SIZE_1W) || (size == SIZE_4W) || (size == SIZE_8W);
  endfunction

  function automatic logic [3:0] size_to_words(input logic [3:0] size);
    case (size)
      SIZE_1W: return 4'd1;
      SIZE_4W: return 4'd4;
      SIZE_8W: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] size_to_beats(input logic [3:0] size);
    case (size)
      SIZE_1W: return 3'd1;
      SIZE_4W: return 3'd2;
      SIZE_8W: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Index of the final beat, sized to match the 2-bit beat counter.
  function automatic logic [1:0] size_to_last_beat(input logic [3:0] size);
    logic [2:0] beats;
    beats = size_to_beats(size) - 3'd1;
    return beats[1:0];
  endfunction

endpackage

// File: rtl/ip_codma_resp_mem.sv
// Word-organised scratch RAM for the codma responder: one 64-bit combinational
// read port and one 64-bit write port, each covering words n and n+1.
module ip_codma_resp_mem #(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk_i,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_addr,
  output logic [63:0]                  rd_data,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
  input  logic [1:0]                   wr_en,
  input  logic [63:0]                  wr_data
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] rd_addr_hi;
  logic [AW-1:0] wr_addr_hi;

  // The upper word wraps at the end of the array; range checks upstream keep
  // legal bursts from ever relying on the wrap.
  assign rd_addr_hi = rd_addr + AW'(1);
  assign wr_addr_hi = wr_addr + AW'(1);

  assign rd_data = {mem[rd_addr_hi], mem[rd_addr]};

  always_ff @(posedge clk_i) begin
    if (wr_en[0]) mem[wr_addr]    <= wr_data[31:0];
    if (wr_en[1]) mem[wr_addr_hi] <= wr_data[63:32];
  end

endmodule

// File: rtl/ip_codma_bus_responder.sv
// Codma bus target: grants master requests and serves 64-bit read/write beats
// from an internal 32-bit word memory. Used as the system-memory model.
module ip_codma_bus_responder
  import ip_codma_machine_states_pkg::*;
#(
  parameter int MEM_WORDS    = 256,
  parameter int GRANT_DELAY  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  size_i,
  input  logic        write_valid_i,
  input  logic [63:0] write_data_i,
  output logic        grant_o,
  output logic        read_valid_o,
  output logic [63:0] read_data_o,
  output logic        error_o,
  output logic        busy_o
);

  localparam int AW = $clog2(MEM_WORDS);

  rsp_state_t    state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [3:0]    dly_q, dly_d;

  logic          write_q;
  logic [31:0]   addr_q;
  logic [3:0]    size_q;

  logic [AW-1:0] word_idx;
  logic [32:0]   end_sum;
  logic          req_ok;
  logic          single;
  logic          last_beat;
  logic [63:0]   rd_data;
  logic [1:0]    wr_en;
  logic          grant;
  logic          read_valid;
  logic          error;

  // Request fields are captured once in idle and held for the whole transfer.
  always_ff @(posedge clk_i) begin
    if (state_q == RSP_IDLE && req_i) begin
      write_q <= write_i;
      addr_q  <= addr_i;
      size_q  <= size_i;
    end
  end

  assign word_idx  = addr_q[AW+1:2] + AW'({beat_q, 1'b0});
  assign end_sum   = {3'b000, addr_q[31:2]} + 33'(size_to_words(size_q));
  assign req_ok    = size_legal(size_q) && (addr_q[1:0] == 2'b00) &&
                     (end_sum <= 33'(MEM_WORDS));
  assign single    = (size_q == SIZE_1W);
  assign last_beat = (beat_q == size_to_last_beat(size_q));

  ip_codma_resp_mem #(
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk_i   (clk_i),
    .rd_addr (word_idx),
    .rd_data (rd_data),
    .wr_addr (word_idx),
    .wr_en   (wr_en),
    .wr_data (write_data_i)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RSP_IDLE;
      beat_q  <= 2'd0;
      dly_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    dly_d      = dly_q;
    grant      = 1'b0;
    read_valid = 1'b0;
    error      = 1'b0;
    wr_en      = 2'b00;
    case (state_q)
      RSP_IDLE: begin
        beat_d = 2'd0;
        dly_d  = 4'd0;
        if (req_i) state_d = RSP_GRANT;
      end
      RSP_GRANT: begin
        if (!req_i) begin
          state_d = RSP_DONE;
          dly_d   = 4'd0;
        end else if (!req_ok) begin
          error   = 1'b1;
          state_d = RSP_DONE;
          dly_d   = 4'd0;
        end else if (dly_q == 4'(GRANT_DELAY - 1)) begin
          grant = 1'b1;
          dly_d = 4'd0;
          if (write_q)                state_d = RSP_WRITE;
          else if (READ_LATENCY == 0) state_d = RSP_READ;
          else                        state_d = RSP_WAIT;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      RSP_WAIT: begin
        if (!req_i) begin
          state_d = RSP_DONE;
          dly_d   = 4'd0;
        end else if (dly_q == 4'(READ_LATENCY - 1)) begin
          state_d = RSP_READ;
          dly_d   = 4'd0;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      RSP_READ: begin
        if (!req_i) begin
          state_d = RSP_DONE;
        end else begin
          read_valid = 1'b1;
          if (last_beat) begin
            state_d = RSP_DONE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      RSP_WRITE: begin
        if (!req_i) begin
          state_d = RSP_DONE;
        end else if (write_valid_i) begin
          wr_en = {~single, 1'b1};
          if (last_beat) begin
            state_d = RSP_DONE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      RSP_DONE: begin
        beat_d = 2'd0;
        dly_d  = 4'd0;
        // Holding here until req_i drops keeps a held request from re-granting.
        if (!req_i) state_d = RSP_IDLE;
      end
      default: begin
        error   = 1'b1;
        state_d = RSP_IDLE;
        beat_d  = 2'd0;
        dly_d   = 4'd0;
      end
    endcase
  end

  assign grant_o      = grant;
  assign read_valid_o = read_valid;
  assign read_data_o  = read_valid ? {(single ? 32'h0 : rd_data[63:32]), rd_data[31:0]}
                                   : 64'h0;
  assign error_o      = error;
  assign busy_o       = (state_q != RSP_IDLE);

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Directed bench for the codma bus responder with default parameters
// (256 words, grant one cycle after request, two-cycle read latency).
module tb_ip_codma_bus_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        req_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [3:0]  size_i = 4'h0;
  logic        write_valid_i = 1'b0;
  logic [63:0] write_data_i = 64'h0;
  logic        grant_o;
  logic        read_valid_o;
  logic [63:0] read_data_o;
  logic        error_o;
  logic        busy_o;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] wbuf [4];
  logic [63:0] rbuf [8];
  int          nread;
  int          first_lat;
  int          glat;
  logic        gnt;
  logic        err;

  ip_codma_bus_responder dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .req_i         (req_i),
    .write_i       (write_i),
    .addr_i        (addr_i),
    .size_i        (size_i),
    .write_valid_i (write_valid_i),
    .write_data_i  (write_data_i),
    .grant_o       (grant_o),
    .read_valid_o  (read_valid_o),
    .read_data_o   (read_data_o),
    .error_o       (error_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, got timeout required completion");
    $fatal(1);
  end

  // Raise a request and wait (bounded) for grant or error; glat counts cycles after the request cycle.
  task automatic start_req(input logic wr, input logic [31:0] a, input logic [3:0] sz);
    @(posedge clk_i); #1;
    req_i = 1'b1; write_i = wr; addr_i = a; size_i = sz;
    glat = -1; gnt = 1'b0; err = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (grant_o || error_o) begin
        gnt = grant_o; err = error_o; glat = c;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic write_beats(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      write_valid_i = 1'b1; write_data_i = wbuf[i];
      if (gap) begin
        @(posedge clk_i); #1;
        write_valid_i = 1'b0;
      end
    end
    @(posedge clk_i); #1;
    write_valid_i = 1'b0;
  endtask

  task automatic read_window();
    first_lat = -1; nread = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      if (read_valid_o) begin
        if (first_lat < 0) first_lat = c;
        if (nread < 8) rbuf[nread] = read_data_o;
        nread++;
      end
    end
  endtask

  task automatic end_req();
    @(posedge clk_i); #1;
    req_i = 1'b0; write_i = 1'b0; write_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] sz, input int n, input bit gap);
    start_req(1'b1, a, sz);
    write_beats(n, gap);
    end_req();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] sz);
    start_req(1'b0, a, sz);
    read_window();
    end_req();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    tests++;
    if ({grant_o, read_valid_o, error_o, busy_o} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000", {grant_o, read_valid_o, error_o, busy_o});
    end
    tests++;
    if (read_data_o !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0", read_data_o);
    end
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_4w();
    start_req(1'b1, 32'h20, 4'd8);
    tests++;
    if (glat !== 1 || gnt !== 1'b1) begin
      fails++;
      $display("FAIL wr_grant: got lat %0d gnt %b required lat 1 gnt 1", glat, gnt);
    end
    wbuf[0] = {32'hB, 32'hA};
    wbuf[1] = {32'hD, 32'hC};
    write_beats(2, 1'b1);
    @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL wr_busy_held: got %b required 1", busy_o);
    end
    @(posedge clk_i); #1;
    req_i = 1'b0; write_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL wr_busy_fall: got %b required 0", busy_o);
    end
    do_read(32'h20, 4'd8);
    tests++;
    if (nread !== 2 || rbuf[0] !== 64'h0000000B_0000000A || rbuf[1] !== 64'h0000000D_0000000C) begin
      fails++;
      $display("FAIL wr_readback: got n=%0d %h %h required n=2 0000000b0000000a 0000000d0000000c",
               nread, rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_read_8w();
    for (int i = 0; i < 4; i++) wbuf[i] = {32'h101 + 32'(2 * i), 32'h100 + 32'(2 * i)};
    do_write(32'h40, 4'd9, 4, 1'b0);
    start_req(1'b0, 32'h40, 4'd9);
    tests++;
    if (glat !== 1 || gnt !== 1'b1) begin
      fails++;
      $display("FAIL rd_grant: got lat %0d gnt %b required lat 1 gnt 1", glat, gnt);
    end
    read_window();
    end_req();
    tests++;
    if (first_lat !== 3 || nread !== 4) begin
      fails++;
      $display("FAIL rd_timing: got first %0d beats %0d required first 3 beats 4", first_lat, nread);
    end
    tests++;
    if (rbuf[0] !== 64'h00000101_00000100 || rbuf[1] !== 64'h00000103_00000102 ||
        rbuf[2] !== 64'h00000105_00000104 || rbuf[3] !== 64'h00000107_00000106) begin
      fails++;
      $display("FAIL rd_data: got %h %h %h %h required 0000010100000100..0000010700000106",
               rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
  endtask

  task automatic test_single_word();
    wbuf[0] = {32'h22222222, 32'h11111111};
    wbuf[1] = {32'h44444444, 32'h33333333};
    do_write(32'h0, 4'd8, 2, 1'b0);
    wbuf[0] = 64'hFFFFFFFF_12345678;
    do_write(32'h0, 4'd3, 1, 1'b0);
    do_read(32'h0, 4'd3);
    tests++;
    if (nread !== 1 || rbuf[0] !== 64'h00000000_12345678) begin
      fails++;
      $display("FAIL single_read: got n=%0d %h required n=1 0000000012345678", nread, rbuf[0]);
    end
    do_read(32'h0, 4'd8);
    tests++;
    if (rbuf[0] !== 64'h22222222_12345678 || rbuf[1] !== 64'h44444444_33333333) begin
      fails++;
      $display("FAIL single_neighbour: got %h %h required 2222222212345678 4444444433333333",
               rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [3];
    logic [3:0]  es [3];
    ea[0] = 32'h0;   es[0] = 4'd5;
    ea[1] = 32'h3F0; es[1] = 4'd9;
    ea[2] = 32'h42;  es[2] = 4'd3;
    for (int i = 0; i < 3; i++) begin
      start_req(1'b0, ea[i], es[i]);
      tests++;
      if (err !== 1'b1 || gnt !== 1'b0 || glat !== 1) begin
        fails++;
        $display("FAIL err_case%0d: got err %b gnt %b lat %0d required err 1 gnt 0 lat 1", i, err, gnt, glat);
      end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      tests++;
      if (error_o !== 1'b0 || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL err_pulse%0d: got err %b busy %b required err 0 busy 1", i, error_o, busy_o);
      end
      end_req();
    end
    start_req(1'b0, 32'h3E0, 4'd9);
    tests++;
    if (gnt !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL err_boundary_ok: got gnt %b err %b required gnt 1 err 0", gnt, err);
    end
    end_req();
  endtask

  task automatic test_abort();
    bit seen;
    int extra;
    seen = 1'b0;
    extra = 0;
    start_req(1'b0, 32'h40, 4'd9);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      if (read_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (seen !== 1'b1) begin
      fails++;
      $display("FAIL abort_first_beat: got none required one beat within 10 cycles");
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      if (read_valid_o) extra++;
      @(posedge clk_i); #1;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL abort_no_beats: got %0d beats required 0", extra);
    end
    @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got busy %b required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 4; i++) wbuf[i] = {32'h51 + 32'(2 * i), 32'h50 + 32'(2 * i)};
    do_write(32'h80, 4'd9, 4, 1'b0);
    start_req(1'b1, 32'h80, 4'd9);
    @(posedge clk_i); #1;
    write_valid_i = 1'b1; write_data_i = 64'h000000C1_000000C0;
    @(posedge clk_i); #1;
    write_valid_i = 1'b0;
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_busy_before: got %b required 1", busy_o);
    end
    reset_n_i = 1'b0;
    req_i = 1'b0; write_i = 1'b0;
    #1;
    tests++;
    if ({grant_o, read_valid_o, error_o, busy_o} !== 4'b0000 || read_data_o !== 64'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %b %h required 0000 0",
               {grant_o, read_valid_o, error_o, busy_o}, read_data_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    do_read(32'h80, 4'd9);
    tests++;
    if (nread !== 4 || rbuf[0] !== 64'h000000C1_000000C0 || rbuf[1] !== 64'h00000053_00000052 ||
        rbuf[3] !== 64'h00000057_00000056) begin
      fails++;
      $display("FAIL rst_mid_retained: got n=%0d %h %h %h required n=4 000000c1000000c0 0000005300000052 0000005700000056",
               nread, rbuf[0], rbuf[1], rbuf[3]);
    end
  endtask

  task automatic test_held_req();
    int gcount;
    gcount = 0;
    start_req(1'b0, 32'h20, 4'd3);
    tests++;
    if (gnt !== 1'b1) begin
      fails++;
      $display("FAIL held_first_grant: got %b required 1", gnt);
    end
    read_window();
    tests++;
    if (nread !== 1 || rbuf[0] !== 64'h00000000_0000000A) begin
      fails++;
      $display("FAIL held_read: got n=%0d %h required n=1 000000000000000a", nread, rbuf[0]);
    end
    repeat (5) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      if (grant_o) gcount++;
    end
    tests++;
    if (gcount !== 0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL held_no_regrant: got grants %0d busy %b required grants 0 busy 1", gcount, busy_o);
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b1;
    @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b0 || grant_o !== 1'b0) begin
      fails++;
      $display("FAIL held_idle_gap: got busy %b grant %b required 0 0", busy_o, grant_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    tests++;
    if (grant_o !== 1'b1) begin
      fails++;
      $display("FAIL held_regrant: got %b required 1", grant_o);
    end
    end_req();
  endtask

  initial begin
    test_reset();
    test_write_4w();
    test_read_8w();
    test_single_word();
    test_errors();
    test_abort();
    test_reset_mid_write();
    test_held_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
